// File: rtl/down_counter_16_pkg.sv
// Shared definitions for the 16-bit loadable down-counter/timer.
//   WIDTH   : datapath width of the count and reload registers
//   state_t : controller state encoding (IDLE, RUN, DONE; 2'b11 is illegal)
package down_counter_16_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/down_counter_16_decr.sv
// 16-bit ripple-borrow decrementer built from half-subtractors.
// The bits are grouped as four 4-bit slices chained through the borrow.
//   a      : operand
//   d      : a - 1 (modulo 2^16)
//   borrow : borrow out of the top bit; high exactly when a == 0
module decr_16
    import down_counter_16_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] d,
    output logic             borrow
);

    // b[k] is the borrow into bit k; subtracting one means bit 0 always
    // sees a borrow-in.
    logic [WIDTH:0] b;

    assign b[0] = 1'b1;

    genvar gi, gj;
    generate
        for (gi = 0; gi < WIDTH / 4; gi++) begin : g_slice
            for (gj = 0; gj < 4; gj++) begin : g_bit
                localparam int K = gi * 4 + gj;
                // Half-subtractor: difference and borrow-out.
                assign d[K]   = a[K] ^ b[K];
                assign b[K+1] = ~a[K] & b[K];
            end
        end
    endgenerate

    assign borrow = b[WIDTH];

endmodule

// File: rtl/down_counter_16.sv
// 16-bit loadable down-counter/timer with terminal-count pulse and optional
// auto-reload.
//   clk  : rising-edge clock
//   res  : synchronous active-high reset (highest priority)
//   in   : load value
//   load : load `in` into the count and reload registers
//   dec  : decrement strobe, one decrement per cycle while high
//   auto : auto-reload enable, sampled on each dec cycle
//   o    : current count (registered)
//   zero : o == 0 (combinational)
//   tc   : one-cycle terminal-count pulse (registered)
//   busy : state is RUN
module down_counter_16
    import down_counter_16_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             dec,
    input  logic             auto,
    output logic [WIDTH-1:0] o,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    state_t           state_reg, state_next;
    logic             tc_reg, tc_next;

    logic [WIDTH-1:0] dec_value;
    logic             dec_borrow;

    decr_16 u_decr (
        .a      (count_reg),
        .d      (dec_value),
        .borrow (dec_borrow)
    );

    // Next-state selection: load > dec > hold (reset handled in the register).
    always_comb begin
        count_next  = count_reg;
        reload_next = reload_reg;
        state_next  = state_reg;
        tc_next     = 1'b0;

        if (load) begin
            count_next  = in;
            reload_next = in;
            state_next  = (in != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (dec) begin
                        if (dec_borrow) begin
                            // Count already sits at 0: either wrap to the
                            // reload value or expire. The borrow never wraps
                            // the count to all-ones.
                            if (auto) begin
                                count_next = reload_reg;
                            end else begin
                                state_next = ST_DONE;
                            end
                        end else begin
                            count_next = dec_value;
                            // 1 -> 0 transition is the terminal count; the
                            // state stays RUN so the following dec decides
                            // between wrap and expiry.
                            tc_next    = (dec_value == '0);
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                end
                default: begin
                    // Illegal encoding recovers to IDLE.
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            count_reg  <= '0;
            reload_reg <= '0;
            state_reg  <= ST_IDLE;
            tc_reg     <= 1'b0;
        end else begin
            count_reg  <= count_next;
            reload_reg <= reload_next;
            state_reg  <= state_next;
            tc_reg     <= tc_next;
        end
    end

    assign o    = count_reg;
    assign zero = (count_reg == '0);
    assign tc   = tc_reg;
    assign busy = (state_reg == ST_RUN);

endmodule

// File: tb/tb_down_counter_16.sv
// Self-checking bench for down_counter_16: directed scenarios with literal
// expectations, then randomized stimulus, all compared every cycle against a
// behavioural reference model.
module tb_down_counter_16;
    import down_counter_16_pkg::*;

    logic             clk = 1'b0;
    logic             res = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic             load = 1'b0;
    logic             dec = 1'b0;
    logic             auto = 1'b0;
    logic [WIDTH-1:0] o;
    logic             zero;
    logic             tc;
    logic             busy;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    down_counter_16 dut (
        .clk  (clk),
        .res  (res),
        .in   (in),
        .load (load),
        .dec  (dec),
        .auto (auto),
        .o    (o),
        .zero (zero),
        .tc   (tc),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Behavioural reference model.
    int     m_o    = 0;
    int     m_rl   = 0;
    state_t m_mode = ST_IDLE;
    bit     m_tc   = 1'b0;

    always @(posedge clk) begin
        if (res) begin
            m_o = 0; m_rl = 0; m_mode = ST_IDLE; m_tc = 1'b0;
        end else if (load) begin
            m_o = int'(in); m_rl = int'(in);
            m_mode = (in != 0) ? ST_RUN : ST_IDLE;
            m_tc = 1'b0;
        end else if (dec && m_mode == ST_RUN) begin
            if (m_o > 1) begin
                m_o = m_o - 1; m_tc = 1'b0;
            end else if (m_o == 1) begin
                m_o = 0; m_tc = 1'b1;
            end else if (auto) begin
                m_o = m_rl; m_tc = 1'b0;
            end else begin
                m_mode = ST_DONE; m_tc = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (int'(o) != m_o || zero != (m_o == 0) || tc != m_tc ||
                busy != (m_mode == ST_RUN)) begin
                failed++;
                $display("FAIL model t=%0t o=%h zero=%b tc=%b busy=%b expected o=%h zero=%b tc=%b busy=%b",
                         $time, o, zero, tc, busy, m_o[15:0], (m_o == 0), m_tc, (m_mode == ST_RUN));
            end
        end
    end

    task automatic drive(input bit r, input bit l, input bit d, input bit a,
                         input logic [WIDTH-1:0] v);
        res = r; load = l; dec = d; auto = a; in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act_o,
                         input logic [WIDTH-1:0] exp_o, input bit act_tc,
                         input bit exp_tc, input bit act_busy, input bit exp_busy);
        tests++;
        if (act_o != exp_o || act_tc != exp_tc || act_busy != exp_busy) begin
            failed++;
            $display("FAIL %s o=%h tc=%b busy=%b expected o=%h tc=%b busy=%b",
                     name, act_o, act_tc, act_busy, exp_o, exp_tc, exp_busy);
        end else begin
            $display("[TB] %s o=%h tc=%b busy=%b ok", name, act_o, act_tc, act_busy);
        end
    endtask

    initial begin
        bit a_r;
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] exp_seq1 [6];
        logic [WIDTH-1:0] exp_seq2 [6];
        exp_seq1 = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0};
        exp_seq2 = '{16'd2, 16'd1, 16'd0, 16'd2, 16'd1, 16'd0};

        // Reset beats load and dec.
        drive(1, 1, 1, 0, 16'd1234);
        chk_en = 1'b1;
        check("reset", o, 16'd0, tc, 1'b0, busy, 1'b0);
        tests++;
        if (zero !== 1'b1) begin
            failed++;
            $display("FAIL reset_zero zero=%b expected 1", zero);
        end

        // One-shot: 3,2,1,0(tc),0(busy drops),0.
        drive(0, 1, 0, 0, 16'd3);
        check("oneshot_0", o, exp_seq1[0], tc, 1'b0, busy, 1'b1);
        for (int i = 1; i < 6; i++) begin
            drive(0, 0, 1, 0, 16'd0);
            check($sformatf("oneshot_%0d", i), o, exp_seq1[i], tc, (i == 3), busy, (i <= 3));
        end

        // Auto-reload period 3.
        drive(0, 1, 0, 1, 16'd2);
        check("auto_0", o, exp_seq2[0], tc, 1'b0, busy, 1'b1);
        for (int i = 1; i < 6; i++) begin
            drive(0, 0, 1, 1, 16'd0);
            check($sformatf("auto_%0d", i), o, exp_seq2[i], tc, (i == 2 || i == 5), busy, 1'b1);
        end

        // Load beats dec in the same cycle.
        drive(0, 1, 0, 0, 16'd5);
        drive(0, 1, 1, 0, 16'hFFFF);
        check("prio_load", o, 16'hFFFF, tc, 1'b0, busy, 1'b1);
        drive(0, 0, 1, 0, 16'd0);
        check("prio_dec", o, 16'hFFFE, tc, 1'b0, busy, 1'b1);

        // Load zero, then reset mid-count.
        drive(0, 1, 0, 0, 16'd0);
        check("load_zero", o, 16'd0, tc, 1'b0, busy, 1'b0);
        drive(0, 1, 0, 0, 16'd10);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 16'd0);
        check("mid_count", o, 16'd6, tc, 1'b0, busy, 1'b1);
        drive(1, 0, 1, 0, 16'd0);
        check("mid_reset", o, 16'd0, tc, 1'b0, busy, 1'b0);
        drive(0, 0, 1, 0, 16'd0);
        check("dec_after_reset", o, 16'd0, tc, 1'b0, busy, 1'b0);

        // Gated strobe across the nibble boundary.
        drive(0, 1, 0, 0, 16'h0100);
        drive(0, 0, 1, 0, 16'd0);
        check("gated_dec", o, 16'h00FF, tc, 1'b0, busy, 1'b1);
        drive(0, 0, 0, 0, 16'd0);
        check("gated_hold", o, 16'h00FF, tc, 1'b0, busy, 1'b1);
        drive(0, 0, 1, 0, 16'd0);
        check("gated_dec2", o, 16'h00FE, tc, 1'b0, busy, 1'b1);

        // Randomized stimulus against the model.
        a_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) a_r = ~a_r;
            v = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, a_r, v);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/down_counter_16.md
# down_counter_16

16-bit loadable down-counter/timer: the decrementing counterpart of the program-counter register, built from the same gate-level adder, mux and register primitives. Software or control logic loads a count. The block decrements it on each `dec` strobe and flags the terminal count. An optional auto-reload mode makes it a periodic tick source for the CPU's timer/delay logic.

## Interface
Parameters: none (width fixed at 16, matching the datapath).

Ports (clock and reset first):
- `clk`  input  1  rising-edge clock; single clock domain.
- `res`  input  1  reset. Synchronous, active-high. Highest priority.
- `in`  input  16  load value.
- `load`  input  1  load `in` into count and reload registers.
- `dec`  input  1  decrement strobe; one decrement per cycle while high.
- `auto`  input  1  auto-reload enable. Sampled on each `dec` cycle.
- `o`  output  16  current count (register output).
- `zero`  output  1  combinational, `o == 16'h0000`.
- `tc`  output  1  terminal-count pulse. Registered, one cycle wide.
- `busy`  output  1  high when state is RUN.

## Operation
- Registers: count `o[15:0]`, reload `rl[15:0]`, state `st[1:0]`, `tc`.
- States:
  - IDLE (00): after reset.
  - RUN (01): counting.
  - DONE (10): expired, non-auto.
  - Encoding 11 is illegal and returns to IDLE on the next edge.
- Priority per edge: `res` > `load` > `dec` > hold.
- `res`: `o`=0, `rl`=0, `st`=IDLE, `tc`=0.
- `load`:
  - `o`=`in`, `rl`=`in`, `tc`=0. `dec` is ignored in the same cycle.
  - `st`=RUN if `in`≠0, else IDLE.
- `dec` in RUN, `o`>1: `o`=`o`−1, `tc`=0.
- `dec` in RUN, `o`==1:
  - `o`=0, `tc`=1.
  - Then `st`=RUN if `auto`, else DONE.
- `dec` in RUN, `o`==0, `auto`=1 (the wrap cycle): `o`=`rl`, `tc`=0, `st` stays RUN. Period = `rl`+1 `dec` cycles.
- `dec` in RUN, `o`==0, `auto`=0: `st`=DONE, `o` holds at 0, `tc`=0.
- `dec` in IDLE or DONE: no change. Count saturates at 0 and never wraps to FFFF.
- `auto` cleared while the count sits at 0 in RUN: the next `dec` moves to DONE.
- No `dec`: all registers hold, and `tc` returns to 0.
- Arithmetic: `o`−1 is formed by a gate-level 16-bit decrementer (ripple borrow). The borrow-out is used only for the `o`==0 test, never to wrap.

## Timing
- All state changes occur on the rising `clk` edge. `o`, `busy` and `tc` reflect an input one cycle after it is sampled. `zero` follows `o` combinationally.
- `tc` is high for exactly the one cycle in which `o` first reads 0 after a decrement from 1. It is never high in consecutive cycles.
- `load` and `dec` in the same cycle: the load wins, and the count equals `in` (not `in`−1).
- `res` mid-count: next cycle `o`=0, `busy`=0, `tc`=0. Any pending `tc` is suppressed.
- `load` while in DONE or IDLE restarts counting. No idle cycle is required.
- Decrement critical path: a 16-stage borrow ripple plus three 16-bit muxes, within one cycle.

## Structure
- The shared include holds the state encodings (`ST_IDLE`, `ST_RUN`, `ST_DONE`) and the width constant 16.
- The shared include is used by the bench.
- One natural sub-module: `decr_16`. It is a 16-bit decrementer from half-subtractors (xor/and/not primitives), grouped as four 4-bit ripple slices with borrow out.
- Top level: `decr_16`, a mux chain for next-count selection (hold/dec/reload/load/reset), the 16-bit `register` for `o` and `rl`, and DFFs for `st` and `tc`.

## Test plan
- Reset: assert `res` with `load`=`dec`=1 and `in`=1234 → next cycle `o`=0, `zero`=1, `busy`=0, `tc`=0.
- One-shot: load 3, `dec` held high, `auto`=0.
  - `o` reads 3,2,1,0,0,… on consecutive cycles.
  - `tc`=1 only in the cycle where `o` first reads 0.
  - `busy` drops to 0 the cycle after that.
  - Further `dec` leaves `o`=0 (no FFFF).
- Auto-reload: load 2, `auto`=1, `dec` held high.
  - `o` sequence 2,1,0,2,1,0,…
  - `tc` pulses every 3 cycles.
  - `busy` stays 1.
- Priority: `o`=5 in RUN, then `load`=1, `dec`=1, `in`=16'hFFFF → next `o`=FFFF, `tc`=0. Following `dec` → FFFE.
- Load zero / mid-reset: load 0 → `busy`=0, `zero`=1, no `tc`. Load 10, `dec` 4 cycles (`o`=6), pulse `res` → `o`=0, `busy`=0; `dec` thereafter has no effect.
- Gated strobe: load 16'h0100 with `dec` toggling every other cycle → borrow ripple is correct across the nibble boundary (0100→00FF). `o` changes only on cycles following `dec`=1.
